// File: rtl/register_frame_sender.sv
// register_frame_sender: transmit side of the register-controller byte link.
// Snapshots six DDS nibbles on start, sends SOF / 6 data / [checksum] / EOF
// under a valid/ready handshake, then waits (bounded) for an ACK/NAK byte.
// Optional feature macro: FRAME_CHECKSUM_EN (adds the XOR checksum byte).
module register_frame_sender #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] Byte_0,
  input  logic [3:0] Byte_1,
  input  logic [3:0] Byte_2,
  input  logic [3:0] Byte_3,
  input  logic [3:0] Byte_4,
  input  logic [3:0] Byte_5,
  output logic [7:0] tx_out,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_in,
  input  logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] status
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] SOF_BYTE = 8'h02;
  localparam logic [7:0] EOF_BYTE = 8'h03;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_DATA, S_CSUM, S_EOF, S_WAIT_ACK, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [5:0][3:0]   nib_q, nib_d;
  logic [1:0]        status_q, status_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [3:0]        cur_nib;
  logic [7:0]        data_byte;

  // Select the snapshot nibble addressed by the data index.
  always_comb begin
    cur_nib = '0;
    case (idx_q)
      3'd0:    cur_nib = nib_q[0];
      3'd1:    cur_nib = nib_q[1];
      3'd2:    cur_nib = nib_q[2];
      3'd3:    cur_nib = nib_q[3];
      3'd4:    cur_nib = nib_q[4];
      3'd5:    cur_nib = nib_q[5];
      default: cur_nib = '0;
    endcase
    data_byte = {1'b0, idx_q, cur_nib};
  end

  // Next-state and output decode for the frame / response FSM.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    nib_d    = nib_q;
    status_d = status_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    tx_out   = '0;
    tx_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          nib_d   = {Byte_5, Byte_4, Byte_3, Byte_2, Byte_1, Byte_0};
          idx_d   = '0;
`ifdef FRAME_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = S_SOF;
        end
      end
      S_SOF: begin
        tx_valid = 1'b1;
        tx_out   = SOF_BYTE;
        if (tx_ready) state_d = S_DATA;
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_out   = data_byte;
        if (tx_ready) begin
`ifdef FRAME_CHECKSUM_EN
          csum_d = csum_q ^ data_byte;
`endif
          if (idx_q == 3'd5) begin
            idx_d = '0;
`ifdef FRAME_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_EOF;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_out   = csum_q;
        if (tx_ready) state_d = S_EOF;
      end
`endif
      S_EOF: begin
        tx_valid = 1'b1;
        tx_out   = EOF_BYTE;
        if (tx_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + CW'(1);
        // ACK/NAK is tested before the timeout so it wins on a tie.
        if (rx_valid && rx_in == ACK_BYTE) begin
          status_d = 2'b00;
          state_d  = S_DONE;
        end else if (rx_valid && rx_in == NAK_BYTE) begin
          status_d = 2'b01;
          state_d  = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          status_d = 2'b10;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      nib_q    <= '0;
      status_q <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      nib_q    <= nib_d;
      status_q <= status_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign status = status_q;

endmodule
